// File: rtl/pwm_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_feeder
// Brief    : Buffers signed audio samples and hands one per tick to a 32-bit
//            PWM as an attenuated, offset-binary duty-cycle word.
// Options  : PWM_FEEDER_STATS_EN adds a saturating underflow_count output.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sample_feeder #(
  parameter int SAMPLE_W    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int TICK_PERIOD = 2268,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic [3:0]                  shift_in,
  output logic [31:0]                 dc_out,
  output logic                        dc_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef PWM_FEEDER_STATS_EN
  output logic [15:0]                 underflow_count,
`endif
  output logic                        underflow
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_PERIOD - 1);
  localparam logic [c_LVL_W-1:0] c_DEPTH     = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_LVL_W-1:0] c_PRIME     = c_LVL_W'(PRIME_LEVEL);
  localparam logic [31:0]        c_MIDSCALE  = 32'h8000_0000;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q;
  logic [c_CNT_W-1:0]    tick_cnt_q;
  logic [c_PTR_W-1:0]    wr_ptr_q;
  logic [c_PTR_W-1:0]    rd_ptr_q;
  logic [c_LVL_W-1:0]    level_q;
  logic [c_LVL_W-1:0]    level_d;
  logic                  ready_q;
  logic [31:0]           dc_q;
  logic                  dc_valid_q;
  logic                  underflow_q;
  logic [SAMPLE_W-1:0]   mem_q [FIFO_DEPTH];

  logic                  w_tick;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_starve;
  logic [SAMPLE_W-1:0]   w_head;
  logic signed [SAMPLE_W-1:0] w_shifted;
  logic [31:0]           w_conv;

  always_comb begin
    w_tick   = (tick_cnt_q == c_TICK_LAST);
    w_empty  = (level_q == '0);
    w_push   = sample_valid & ready_q;
    w_pop    = w_tick & ((state_q == ST_RUN) ? ~w_empty : (level_q >= c_PRIME));
    w_starve = w_tick & (state_q == ST_RUN) & w_empty;

    unique case ({w_push, w_pop})
      2'b10:   level_d = level_q + c_LVL_W'(1);
      2'b01:   level_d = level_q - c_LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Offset-binary conversion; very large shifts pin to the sign's extreme so
  // a negative sample never collapses to just-below-midscale.
  always_comb begin
    w_head    = mem_q[rd_ptr_q];
    w_shifted = $signed(w_head) >>> shift_in;
    if (32'(shift_in) >= 32'(SAMPLE_W - 1)) begin
      w_conv = w_head[SAMPLE_W-1] ? 32'h0000_0000 : c_MIDSCALE;
    end else begin
      w_conv = 32'({~w_shifted[SAMPLE_W-1], w_shifted[SAMPLE_W-2:0]}) << (32 - SAMPLE_W);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_PRIME;
      tick_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ready_q     <= 1'b0;
      dc_q        <= c_MIDSCALE;
      dc_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tick_cnt_q <= w_tick ? '0 : tick_cnt_q + c_CNT_W'(1);

      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
        dc_q     <= w_conv;
      end
      level_q <= level_d;
      // Ready follows the post-update level, so a pop never opens a full FIFO
      // to a push in the same cycle.
      ready_q <= (level_d < c_DEPTH);

      dc_valid_q  <= w_pop | w_starve;
      underflow_q <= w_starve;

      unique case (state_q)
        ST_PRIME: if (w_pop)    state_q <= ST_RUN;
        ST_RUN:   if (w_starve) state_q <= ST_PRIME;
        default:                state_q <= ST_PRIME;
      endcase
    end
  end

`ifdef PWM_FEEDER_STATS_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      uf_cnt_q <= '0;
    end else if (w_starve && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign underflow_count = uf_cnt_q;
`endif

  assign sample_ready = ready_q;
  assign dc_out       = dc_q;
  assign dc_valid     = dc_valid_q;
  assign underflow    = underflow_q;
  assign fifo_level   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_sample_feeder
// Brief    : Scoreboard bench for pwm_sample_feeder against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_sample_feeder;

  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int TP    = 16;
  localparam int PL    = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [3:0]  shift_in = '0;
  logic [31:0] dc_out;
  logic        dc_valid;
  logic [3:0]  fifo_level;
  logic        underflow;
`ifdef PWM_FEEDER_STATS_EN
  logic [15:0] underflow_count;
`endif

  pwm_sample_feeder #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH),
    .TICK_PERIOD(TP),
    .PRIME_LEVEL(PL)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .shift_in       (shift_in),
    .dc_out         (dc_out),
    .dc_valid       (dc_valid),
    .fifo_level     (fifo_level),
`ifdef PWM_FEEDER_STATS_EN
    .underflow_count(underflow_count),
`endif
    .underflow      (underflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] dc;
    logic        uf;
  } exp_t;

  logic [15:0] mq[$];
  exp_t        eq[$];
  bit          running  = 1'b0;
  bit          rdy_m    = 1'b0;
  int          cyc      = 0;
  logic [31:0] last_dc  = 32'h8000_0000;
  int          uf_m     = 0;
  int          accepted = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Duty word = (shifted sample + half scale) scaled to the top of 32 bits.
  function automatic logic [31:0] ref_conv(input logic [15:0] smp, input logic [3:0] sh);
    longint v;
    v = longint'($signed(smp));
    if (int'(sh) >= SW - 1) return (v < 0) ? 32'h0000_0000 : 32'h8000_0000;
    v = v >>> sh;
    return 32'((v + (64'sd1 <<< (SW - 1))) * (64'sd1 <<< (32 - SW)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances once per clock edge outside reset.
  initial forever begin
    @(posedge clk_in or negedge rst_in);
    if (!rst_in) begin
      mq.delete();
      eq.delete();
      running = 1'b0;
      rdy_m   = 1'b0;
      cyc     = 0;
      last_dc = 32'h8000_0000;
      uf_m    = 0;
    end else begin
      bit push;
      bit tick;
      push = sample_valid && rdy_m;
      tick = (cyc % TP) == (TP - 1);
      if (tick) begin
        if (mq.size() > 0 && (running || mq.size() >= PL)) begin
          last_dc = ref_conv(mq.pop_front(), shift_in);
          eq.push_back('{last_dc, 1'b0});
          running = 1'b1;
        end else if (running) begin
          eq.push_back('{last_dc, 1'b1});
          running = 1'b0;
          if (uf_m < 65535) uf_m++;
        end
      end
      if (push) begin
        mq.push_back(sample_in);
        accepted++;
      end
      rdy_m = mq.size() < DEPTH;
      cyc++;
    end
  end

  // Monitor: compares DUT outputs shortly after each rising edge.
  initial begin
    bit prev_v;
    bit prev_u;
    exp_t e;
    prev_v = 1'b0;
    prev_u = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in) begin
        check("rst_ready", 32'(sample_ready), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_dc_out", dc_out, 32'h8000_0000);
        check("rst_dc_valid", 32'(dc_valid), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`ifdef PWM_FEEDER_STATS_EN
        check("rst_uf_count", 32'(underflow_count), 32'd0);
`endif
        prev_v = 1'b0;
        prev_u = 1'b0;
      end else begin
        check("sample_ready", 32'(sample_ready), 32'(rdy_m));
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        if (eq.size() > 0) begin
          e = eq.pop_front();
          check("dc_valid", 32'(dc_valid), 32'd1);
          check("dc_out", dc_out, e.dc);
          check("underflow", 32'(underflow), 32'(e.uf));
        end else begin
          check("dc_valid_idle", 32'(dc_valid), 32'd0);
          check("underflow_idle", 32'(underflow), 32'd0);
        end
        check("dc_valid_single", 32'(prev_v && dc_valid), 32'd0);
        check("underflow_single", 32'(prev_u && underflow), 32'd0);
`ifdef PWM_FEEDER_STATS_EN
        check("uf_count", 32'(underflow_count), 32'(uf_m));
`endif
        prev_v = dc_valid;
        prev_u = underflow;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_one(input logic [15:0] v, input logic [3:0] sh);
    int start;
    int n;
    start        = accepted;
    n            = 0;
    sample_in    = v;
    shift_in     = sh;
    sample_valid = 1'b1;
    while (accepted == start) begin
      @(negedge clk_in);
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: sample 0x%04h not accepted, required within 200 cycles", v);
        break;
      end
    end
  endtask

  task automatic idle(input int cycles);
    sample_valid = 1'b0;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_in);
    sample_valid = 1'b0;
    rst_in       = 1'b0;
    repeat (cycles) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    logic [15:0] dir_a [4];
    int rate;
    #1 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;

    // Four midscale samples, then a drain into underflow.
    for (int i = 0; i < 4; i++) push_one(16'h0000, 4'd0);
    idle(5 * TP + 4);

    // Extremes of the sample range.
    dir_a = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    for (int i = 0; i < 4; i++) push_one(dir_a[i], 4'd0);
    idle(5 * TP + 4);

    // Fill to full before the first tick, then offer a ninth sample.
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) push_one(16'(16'h1000 * (i + 1) + 16'h0011), 4'd0);
    sample_in    = 16'h1234;
    sample_valid = 1'b1;
    repeat (3) @(negedge clk_in);
    idle(9 * TP + 4);

    // Attenuation: moderate shift on a positive sample, maximal on a negative.
    do_reset(1);
    for (int i = 0; i < 4; i++) push_one(16'h4000, 4'd2);
    idle(5 * TP + 4);
    for (int i = 0; i < 4; i++) push_one(16'hC000, 4'd15);
    idle(5 * TP + 4);
    shift_in = 4'd0;

    // Reset while running with samples buffered, then re-prime.
    do_reset(1);
    for (int i = 0; i < 6; i++) push_one(16'(16'h0100 * i), 4'd0);
    idle(12);
    do_reset(1);
    idle(2 * TP);
    for (int i = 0; i < 4; i++) push_one(16'(16'h2222 * (i + 1)), 4'd1);
    idle(6 * TP);

    // Randomized traffic at varying offered rates.
    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 4)
        0: rate = 5;
        1: rate = 15;
        2: rate = 40;
        default: rate = 90;
      endcase
      if (blk == 5) do_reset(2);
      for (int c = 0; c < 400; c++) begin
        sample_valid = ($urandom_range(0, 99) < rate);
        sample_in    = 16'($urandom);
        shift_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        @(negedge clk_in);
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_sample_feeder.md
PWM_SAMPLE_FEEDER -- requirements
Module: pwm_sample_feeder

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: width of signed audio samples.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two, at least 4: sample buffer depth.
REQ-003 SHALL have parameter TICK_PERIOD, default 2268: clocks per output sample.
REQ-004 SHALL have parameter PRIME_LEVEL, default 4, range 1 to FIFO_DEPTH: FIFO fill required before output starts.
REQ-005 SHALL have port clk_in, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sample_in, input, SAMPLE_W bits: signed two's-complement sample.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-009 SHALL have port sample_ready, output, 1 bit: block can accept a sample.
REQ-010 SHALL have port shift_in, input, 4 bits: attenuation, arithmetic right shift applied to each sample.
REQ-011 SHALL have port dc_out, output, 32 bits: duty-cycle word for the downstream 32-bit PWM.
REQ-012 SHALL have port dc_valid, output, 1 bit: one-cycle strobe that loads dc_out downstream.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-014 SHALL have port underflow, output, 1 bit: one-cycle pulse on a starved tick.

Function
REQ-015 A sample SHALL be accepted on a clock edge where sample_valid and sample_ready are both 1.
REQ-016 sample_ready SHALL be registered and equal to (fifo_level < FIFO_DEPTH); a pop in the same cycle SHALL NOT make a full FIFO accept a sample.
REQ-017 The tick counter SHALL count 0 to TICK_PERIOD-1 and wrap; it SHALL run continuously from reset release, whatever the state.
REQ-018 A tick SHALL be the cycle in which the counter equals TICK_PERIOD-1.
REQ-019 The state machine SHALL have exactly two states, PRIME and RUN; reset SHALL enter PRIME.
REQ-020 PRIME to RUN SHALL occur on the first tick where fifo_level >= PRIME_LEVEL; that tick SHALL pop and emit.
REQ-021 On a PRIME tick below PRIME_LEVEL, the block SHALL NOT pop, SHALL NOT assert dc_valid, and SHALL NOT assert underflow.
REQ-022 On a RUN tick with the FIFO non-empty, the block SHALL pop the head, and dc_out and dc_valid SHALL update on the next cycle (latency 1 from tick).
REQ-023 On a RUN tick with the FIFO empty, dc_out SHALL hold its value, dc_valid SHALL re-pulse, underflow SHALL pulse, and the state SHALL return to PRIME.
REQ-024 A push in the same cycle as a RUN tick with an empty FIFO SHALL be stored, not bypassed; the tick SHALL still count as an underflow.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Conversion: s = sample >>> shift_in, sign-extended; dc_out = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], (32-SAMPLE_W) zero bits}.
REQ-027 Sample -2^(SAMPLE_W-1) SHALL map to 0, sample 0 to 0x8000_0000, and maximum positive to 0xFFFF_0000 (SAMPLE_W=16).
REQ-028 shift_in SHALL be sampled at pop time; shifts >= SAMPLE_W-1 SHALL give 0x0000_0000 or 0x8000_0000 by sign.
REQ-029 dc_valid and underflow SHALL never be high for more than one consecutive cycle.

Reset
REQ-030 rst_in low SHALL asynchronously force: state PRIME, FIFO empty, tick counter 0, sample_ready 0, dc_out 0x8000_0000, dc_valid 0, underflow 0, fifo_level 0.
REQ-031 sample_ready SHALL rise on the first clock edge after reset release.
REQ-032 Reset mid-operation SHALL discard all buffered samples; no dc_valid SHALL occur until PRIME_LEVEL samples are again buffered.

Configuration
REQ-033 Macro PWM_FEEDER_STATS_EN defined: SHALL add output underflow_count, 16 bits, incremented per underflow pulse, saturating at 0xFFFF, cleared only by reset.
REQ-034 PWM_FEEDER_STATS_EN undefined: underflow_count SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, push 4 samples 0x0000 with TICK_PERIOD=8 -> first dc_valid one cycle after the next tick, dc_out=0x8000_0000, then every 8 cycles.
REQ-036 Push 0x7FFF, 0x8000, 0xFFFF, 0x0001, shift_in=0 -> dc_out 0xFFFF_0000, 0x0000_0000, 0x7FFF_0000, 0x8001_0000 in order.
REQ-037 Push 8 samples with no ticks -> sample_ready=0 and fifo_level=8; a 9th valid is not accepted and FIFO contents are unchanged.
REQ-038 RUN, drain FIFO, next tick -> dc_valid repeats the last dc_out, underflow pulses once, state PRIME, underflow_count=1 with stats enabled.
REQ-039 Sample 0x4000, shift_in=2 -> dc_out 0x9000_0000; sample 0xC000, shift_in=15 -> dc_out 0x0000_0000.
REQ-040 rst_in low for 1 cycle with 5 samples buffered in RUN -> fifo_level=0, dc_out=0x8000_0000, no dc_valid until 4 new samples and a tick.
